mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum mem_ack wait cycles before an access is aborted.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  Execute stage presents a valid instruction this cycle.
REQ-005 alu_in  input  32  Execute ALU result; effective address for loads and stores.
REQ-006 reg2_in  input  32  store data.
REQ-007 wsel_in  input  5  destination register.
REQ-008 flags_in  input  4  {overflow, carryout, negative, zero}.
REQ-009 branch_in  input  32  branch target.
REQ-010 ctr_mem_read, ctr_mem_write, ctr_branch, ctr_reg_write, ctr_mem_to_reg  input  1 each  control bits.
REQ-011 mem_addr, mem_wdata  output  32 each  data-memory bus address and write data.
REQ-012 mem_req, mem_we  output  1 each  data-memory bus request and write enable.
REQ-013 mem_rdata  input  32  data-memory bus read data.
REQ-014 mem_ack  input  1  data-memory bus completion.
REQ-015 stall  output  1  holds the upstream stages.
REQ-016 pc_src  output  1  take branch.
REQ-017 pc_branch  output  32  branch target to fetch.
REQ-018 wb_data  output  32  registered write-back data.
REQ-019 wb_wsel  output  5  registered write-back destination.
REQ-020 wb_reg_write  output  1  registered write-back register-write enable.
REQ-021 wb_valid  output  1  registered write-back valid.
REQ-022 mem_err  output  1  sticky error flag.

Function
REQ-023 A memory op is valid_in & (ctr_mem_read | ctr_mem_write); if both read and write are set, write wins and mem_we=1.
REQ-024 FSM states: IDLE, BUSY. On an IDLE memory op: transition to BUSY; next cycle latch alu_in to mem_addr, reg2_in to mem_wdata and write to mem_we, and set mem_req=1.
REQ-025 BUSY: mem_req stays 1 and mem_addr, mem_wdata and mem_we stay stable until mem_ack=1 is sampled; then mem_req=0 next cycle and the FSM returns to IDLE.
REQ-026 stall = (IDLE & memory op) | (BUSY & ~mem_ack), combinational; the upstream stage holds its inputs while stall=1.
REQ-027 Non-memory op: wb_* loaded one cycle after valid_in (latency 1); wb_data = alu_in.
REQ-028 Load: wb_data = mem_rdata captured in the mem_ack cycle, visible the next cycle; wb_valid pulses for exactly 1 cycle per instruction.
REQ-029 Store: wb_valid=1 and wb_reg_write=0 after mem_ack.
REQ-030 Between accepting a memory op and its completion, wb_valid=0 every cycle.
REQ-031 pc_src = valid_in & ctr_branch & flags_in[0] & ~stall, combinational; pc_branch = branch_in.
REQ-032 An 8-bit wait counter clears on entering BUSY and increments each BUSY cycle without mem_ack.
REQ-033 Timeout abort: if the wait counter reaches TIMEOUT, deassert mem_req, set mem_err, return to IDLE, and emit wb_valid=1 with wb_reg_write=0.
REQ-034 mem_ack outside BUSY is ignored.
REQ-035 mem_addr bits [1:0] are passed unchanged; alignment is not checked.

Reset
REQ-036 When reset=1 at a clock edge, the FSM goes to IDLE, the wait counter clears and mem_err clears.
REQ-037 When reset=1 at a clock edge, mem_req, mem_we, wb_valid and wb_reg_write become 0.
REQ-038 When reset=1 at a clock edge, mem_addr, mem_wdata, wb_data and wb_wsel become 0.
REQ-039 A reset during BUSY aborts the access with no write-back, and mem_req=0 the following cycle.

Structure
REQ-040 Package mem_pkg holds the state enum {IDLE, BUSY}, the flag bit indices (ZERO=0, NEG=1, CARRY=2, OVF=3) and the TIMEOUT default.
REQ-041 Pipeline registers use the existing Reg module and the write-back data select uses the existing Mux.
REQ-042 The FSM and wait counter form one sub-module, mem_access_ctrl.

Verification
REQ-043 ALU op: alu_in=0x1234, wsel_in=5, ctr_reg_write=1 -> next cycle wb_data=0x1234, wb_wsel=5, wb_valid=1, stall=0.
REQ-044 Load at 0x40 with mem_ack after 3 cycles, mem_rdata=0xDEADBEEF -> stall held 4 cycles, mem_addr=0x40, wb_data=0xDEADBEEF for one cycle.
REQ-045 Store with 0x55AA to address 0x80, mem_ack on the first request cycle -> mem_we=1, mem_wdata=0x55AA, wb_valid=1, wb_reg_write=0.
REQ-046 Branch: ctr_branch=1, flags_in=4'b0001, branch_in=0x100 -> pc_src=1, pc_branch=0x100; with flags_in=0 -> pc_src=0.
REQ-047 Load with mem_ack never asserted -> mem_req drops after 16 wait cycles, mem_err=1, stall=0, wb_reg_write=0.
REQ-048 Reset on the second BUSY cycle -> next cycle mem_req=0, stall=0, wb_valid=0, mem_err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory pipeline stage and its access controller.
package mem_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

   // Bit positions inside flags_in = {overflow, carryout, negative, zero}
   localparam int ZERO  = 0;
   localparam int NEG   = 1;
   localparam int CARRY = 2;
   localparam int OVF   = 3;

   localparam int TIMEOUT_DEFAULT = 16;
   localparam int WAIT_W          = 8;

   function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
      return valid & (rd | wr);
   endfunction

endpackage

// File: rtl/Mux.sv
// Generic two-input multiplexer: sel=0 picks in0, sel=1 picks in1.
module Mux #(
   parameter int W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/Reg.sv
// Generic pipeline register with synchronous active-high clear and load enable.
module Reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// IDLE/BUSY handshake controller for the data-memory bus, with wait counter,
// timeout abort and sticky error flag.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_op,
   input  logic mem_ack,
   output logic busy,
   output logic accept,
   output logic ack_done,
   output logic timeout_hit,
   output logic stall,
   output logic mem_req,
   output logic mem_err
);

   localparam logic [WAIT_W-1:0] TIMEOUT_CNT = TIMEOUT[WAIT_W-1:0];

   mem_state_e        state_reg, state_next;
   logic [WAIT_W-1:0] wait_reg, wait_next, wait_inc;
   logic              req_reg, req_next;
   logic              err_reg, err_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         wait_reg  <= '0;
         req_reg   <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
         req_reg   <= req_next;
         err_reg   <= err_next;
      end
   end

   assign wait_inc = wait_reg + 8'd1;

   always_comb begin
      state_next  = state_reg;
      wait_next   = wait_reg;
      req_next    = 1'b0;
      err_next    = err_reg;
      accept      = 1'b0;
      ack_done    = 1'b0;
      timeout_hit = 1'b0;
      stall       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (mem_op) begin
               accept     = 1'b1;
               stall      = 1'b1;
               req_next   = 1'b1;
               wait_next  = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack) begin
               ack_done   = 1'b1;
               wait_next  = '0;
               state_next = IDLE;
            end else if (wait_inc == TIMEOUT_CNT) begin
               // An abort retires the instruction like an ack, so stall is
               // released here; otherwise the held op would be re-issued.
               timeout_hit = 1'b1;
               err_next    = 1'b1;
               wait_next   = '0;
               state_next  = IDLE;
            end else begin
               stall     = 1'b1;
               req_next  = 1'b1;
               wait_next = wait_inc;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy    = (state_reg == BUSY);
   assign mem_req = req_reg;
   assign mem_err = err_reg;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data-memory bus for loads/stores, resolves
// branches and registers the write-back bundle.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] reg2_in,
   input  logic [4:0]  wsel_in,
   input  logic [3:0]  flags_in,
   input  logic [31:0] branch_in,
   input  logic        ctr_mem_read,
   input  logic        ctr_mem_write,
   input  logic        ctr_branch,
   input  logic        ctr_reg_write,
   input  logic        ctr_mem_to_reg,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_req,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] pc_branch,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_wsel,
   output logic        wb_reg_write,
   output logic        wb_valid,
   output logic        mem_err
);

   logic        mem_op;
   logic        busy, accept, ack_done, timeout_hit;
   logic        alu_issue, wb_load;
   logic [4:0]  wsel_hold;
   logic        rw_hold;
   logic [31:0] alu_value, wb_data_next;
   logic [4:0]  wb_wsel_next;
   logic        wb_valid_next, wb_reg_write_next;
   logic        unused_inputs;

   assign mem_op = is_mem_op(valid_in, ctr_mem_read, ctr_mem_write);

   mem_access_ctrl #(
      .TIMEOUT (TIMEOUT)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .mem_op      (mem_op),
      .mem_ack     (mem_ack),
      .busy        (busy),
      .accept      (accept),
      .ack_done    (ack_done),
      .timeout_hit (timeout_hit),
      .stall       (stall),
      .mem_req     (mem_req),
      .mem_err     (mem_err)
   );

   // Bus-side registers are captured once, when the op is accepted, so they
   // stay stable for the whole access.
   Reg #(.W(32)) u_addr_reg  (.clk(clk), .reset(reset), .en(accept), .d(alu_in),  .q(mem_addr));
   Reg #(.W(32)) u_wdata_reg (.clk(clk), .reset(reset), .en(accept), .d(reg2_in), .q(mem_wdata));
   Reg #(.W(1))  u_we_reg    (.clk(clk), .reset(reset), .en(accept), .d(ctr_mem_write), .q(mem_we));
   Reg #(.W(5))  u_wsel_hold (.clk(clk), .reset(reset), .en(accept), .d(wsel_in), .q(wsel_hold));
   Reg #(.W(1))  u_rw_hold   (.clk(clk), .reset(reset), .en(accept),
                              .d(ctr_reg_write & ~ctr_mem_write), .q(rw_hold));

   // While busy the inputs are the held memory op itself, never a new instruction.
   assign alu_issue = valid_in & ~mem_op & ~busy;
   assign wb_load   = ack_done & ~mem_we;
   assign alu_value = busy ? mem_addr : alu_in;

   Mux #(.W(32)) u_wb_mux (
      .sel (wb_load),
      .in0 (alu_value),
      .in1 (mem_rdata),
      .out (wb_data_next)
   );

   assign wb_valid_next     = alu_issue | ack_done | timeout_hit;
   assign wb_reg_write_next = (alu_issue & ctr_reg_write) | (ack_done & rw_hold);
   assign wb_wsel_next      = busy ? wsel_hold : wsel_in;

   Reg #(.W(32)) u_wb_data  (.clk(clk), .reset(reset), .en(wb_valid_next), .d(wb_data_next), .q(wb_data));
   Reg #(.W(5))  u_wb_wsel  (.clk(clk), .reset(reset), .en(wb_valid_next), .d(wb_wsel_next), .q(wb_wsel));
   Reg #(.W(1))  u_wb_valid (.clk(clk), .reset(reset), .en(1'b1), .d(wb_valid_next), .q(wb_valid));
   Reg #(.W(1))  u_wb_rw    (.clk(clk), .reset(reset), .en(1'b1), .d(wb_reg_write_next), .q(wb_reg_write));

   assign pc_src    = valid_in & ctr_branch & flags_in[ZERO] & ~stall;
   assign pc_branch = branch_in;

   // Only the zero flag steers branches; a load always returns read data.
   assign unused_inputs = ^{flags_in[OVF], flags_in[CARRY], flags_in[NEG], ctr_mem_to_reg};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-cycle expectation timeline built from
// instruction-level rules, directed literal pins, then randomized traffic.
module tb_mem_stage;

   localparam int TO   = 16;
   localparam int MAXC = 16384;
   localparam int BIG  = 1 << 30;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] alu_in, reg2_in, branch_in, mem_rdata;
   logic [4:0]  wsel_in;
   logic [3:0]  flags_in;
   logic        ctr_mem_read, ctr_mem_write, ctr_branch, ctr_reg_write, ctr_mem_to_reg;
   logic        mem_ack;
   logic [31:0] mem_addr, mem_wdata, pc_branch, wb_data;
   logic        mem_req, mem_we, stall, pc_src, wb_reg_write, wb_valid, mem_err;
   logic [4:0]  wb_wsel;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in), .reg2_in(reg2_in),
      .wsel_in(wsel_in), .flags_in(flags_in), .branch_in(branch_in),
      .ctr_mem_read(ctr_mem_read), .ctr_mem_write(ctr_mem_write), .ctr_branch(ctr_branch),
      .ctr_reg_write(ctr_reg_write), .ctr_mem_to_reg(ctr_mem_to_reg),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .pc_src(pc_src),
      .pc_branch(pc_branch), .wb_data(wb_data), .wb_wsel(wb_wsel),
      .wb_reg_write(wb_reg_write), .wb_valid(wb_valid), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected behaviour per cycle, indexed by cycle number
   bit          exp_stall [MAXC];
   bit          exp_pc    [MAXC];
   bit          exp_req   [MAXC];
   bit          exp_we    [MAXC];
   bit          exp_wbv   [MAXC];
   bit          exp_wbrw  [MAXC];
   bit          exp_dchk  [MAXC];
   bit          exp_schk  [MAXC];
   logic [31:0] exp_addr  [MAXC];
   logic [31:0] exp_wdata [MAXC];
   logic [31:0] exp_wbdat [MAXC];
   logic [4:0]  exp_wsel  [MAXC];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int err_since = BIG;

   function automatic logic [13:0] ix(input int c);
      return c[13:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Monitor: last-cycle samples and running counts used by the literal pins
   logic        last_pc_src, last_stall;
   logic [31:0] last_pc_branch;
   int          stall_cnt = 0;
   int          req_cnt = 0;
   always @(negedge clk) begin
      last_pc_src    <= pc_src;
      last_pc_branch <= pc_branch;
      last_stall     <= stall;
      if (stall === 1'b1) stall_cnt <= stall_cnt + 1;
      if (mem_req === 1'b1) req_cnt <= req_cnt + 1;
   end

   // Compare process: DUT against the timeline on every checked cycle
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'd0, stall}, {31'd0, exp_stall[ix(cyc)]});
         check("pc_src", {31'd0, pc_src}, {31'd0, exp_pc[ix(cyc)]});
         check("pc_branch", pc_branch, branch_in);
         check("mem_req", {31'd0, mem_req}, {31'd0, exp_req[ix(cyc)]});
         if (exp_req[ix(cyc)]) begin
            check("mem_addr", mem_addr, exp_addr[ix(cyc)]);
            check("mem_wdata", mem_wdata, exp_wdata[ix(cyc)]);
            check("mem_we", {31'd0, mem_we}, {31'd0, exp_we[ix(cyc)]});
         end
         check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wbv[ix(cyc)]});
         check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_wbrw[ix(cyc)]});
         if (exp_wbv[ix(cyc)] && exp_dchk[ix(cyc)])
            check("wb_data", wb_data, exp_wbdat[ix(cyc)]);
         if (exp_wbv[ix(cyc)] && exp_schk[ix(cyc)])
            check("wb_wsel", {27'd0, wb_wsel}, {27'd0, exp_wsel[ix(cyc)]});
         check("mem_err", {31'd0, mem_err}, {31'd0, (cyc >= err_since)});
      end
   end

   // Present one instruction (or an idle slot when v=0) as the upstream stage
   // and the memory would; waits = request cycles before the ack, >= TO means no ack.
   task automatic run_instr(input bit v, input bit rd, input bit wr, input bit br, input bit rw,
                            input logic [31:0] alu, input logic [31:0] r2, input logic [31:0] bt,
                            input logic [4:0] ws, input logic [3:0] fl, input int waits,
                            input logic [31:0] rdata);
      int c;
      int k;
      bit acked;
      bit memop;
      c = cyc;
      valid_in = v; ctr_mem_read = rd; ctr_mem_write = wr; ctr_branch = br;
      ctr_reg_write = rw; ctr_mem_to_reg = rd; alu_in = alu; reg2_in = r2;
      branch_in = bt; wsel_in = ws; flags_in = fl;
      memop = v && (rd || wr);
      if (v)
         $display("txn cyc=%0d op=%s alu=0x%08h wsel=%0d waits=%0d", c,
                  memop ? (wr ? "store" : "load") : (br ? "branch" : "alu"), alu, ws, waits);
      if (!memop) begin
         exp_pc[ix(c)] = v & br & fl[0];
         if (v) begin
            exp_wbv[ix(c+1)] = 1'b1;  exp_wbrw[ix(c+1)] = rw;
            exp_dchk[ix(c+1)] = 1'b1; exp_wbdat[ix(c+1)] = alu;
            exp_schk[ix(c+1)] = 1'b1; exp_wsel[ix(c+1)] = ws;
         end
         mem_ack = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(posedge clk); #1;
      end else begin
         acked = (waits < TO);
         k = acked ? waits + 1 : TO;
         for (int i = 0; i <= k; i++) begin
            exp_stall[ix(c+i)] = (i < k);
            if (i > 0) begin
               exp_req[ix(c+i)] = 1'b1;  exp_addr[ix(c+i)] = alu;
               exp_wdata[ix(c+i)] = r2;  exp_we[ix(c+i)] = wr;
            end
         end
         exp_wbv[ix(c+k+1)]   = 1'b1;
         exp_wbrw[ix(c+k+1)]  = acked & !wr & rw;
         exp_dchk[ix(c+k+1)]  = acked & !wr;
         exp_wbdat[ix(c+k+1)] = rdata;
         exp_schk[ix(c+k+1)]  = acked;
         exp_wsel[ix(c+k+1)]  = ws;
         if (!acked && (c + k + 1) < err_since) err_since = c + k + 1;
         for (int i = 0; i <= k; i++) begin
            if (i == 0) begin
               mem_ack = 1'($urandom_range(0, 1));
               mem_rdata = $urandom;
            end else if (acked && i == k) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end else begin
               mem_ack = 1'b0;
               mem_rdata = $urandom;
            end
            @(posedge clk); #1;
         end
      end
      valid_in = 1'b0;
      mem_ack  = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0;
      int r0;
      int w;
      int kind;
      int waits;
      reset = 1'b1; valid_in = 1'b0; alu_in = '0; reg2_in = '0; wsel_in = '0;
      flags_in = '0; branch_in = '0; ctr_mem_read = 1'b0; ctr_mem_write = 1'b0;
      ctr_branch = 1'b0; ctr_reg_write = 1'b0; ctr_mem_to_reg = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_wsel", {27'd0, wb_wsel}, 32'd0);
      check("rst_mem_err", {31'd0, mem_err}, 32'd0);
      @(posedge clk); #1;
      chk_en = 1'b1;

      // ALU op
      run_instr(1, 0, 0, 0, 1, 32'h1234, 32'h0, 32'h0, 5'd5, 4'h0, 0, 32'h0);
      check("alu_stall", {31'd0, last_stall}, 32'd0);
      @(negedge clk);
      check("alu_wb_data", wb_data, 32'h1234);
      check("alu_wb_wsel", {27'd0, wb_wsel}, 32'd5);
      check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      @(posedge clk); #1;

      // Load with three wait cycles before the ack
      s0 = stall_cnt;
      run_instr(1, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0, 5'd7, 4'h0, 3, 32'hDEADBEEF);
      check("load_stall_cycles", stall_cnt - s0, 32'd4);
      @(negedge clk);
      check("load_mem_addr", mem_addr, 32'h40);
      check("load_wb_data", wb_data, 32'hDEADBEEF);
      check("load_wb_valid", {31'd0, wb_valid}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("load_wb_pulse", {31'd0, wb_valid}, 32'd0);
      @(posedge clk); #1;

      // Store acked on the first request cycle
      run_instr(1, 0, 1, 0, 0, 32'h80, 32'h55AA, 32'h0, 5'd3, 4'h0, 0, 32'h0);
      @(negedge clk);
      check("store_mem_we", {31'd0, mem_we}, 32'd1);
      check("store_mem_wdata", mem_wdata, 32'h55AA);
      check("store_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("store_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      @(posedge clk); #1;

      // Branch taken / not taken
      run_instr(1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h100, 5'd0, 4'b0001, 0, 32'h0);
      check("branch_pc_src", {31'd0, last_pc_src}, 32'd1);
      check("branch_pc_branch", last_pc_branch, 32'h100);
      run_instr(1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h100, 5'd0, 4'b0000, 0, 32'h0);
      check("branch_not_taken", {31'd0, last_pc_src}, 32'd0);

      // Load that is never acked
      s0 = stall_cnt;
      r0 = req_cnt;
      run_instr(1, 1, 0, 0, 1, 32'h200, 32'h0, 32'h0, 5'd9, 4'h0, TO, 32'h0);
      check("timeout_stall_cycles", stall_cnt - s0, 32'd16);
      check("timeout_req_cycles", req_cnt - r0, 32'd16);
      @(negedge clk);
      check("timeout_mem_req", {31'd0, mem_req}, 32'd0);
      check("timeout_mem_err", {31'd0, mem_err}, 32'd1);
      check("timeout_stall", {31'd0, stall}, 32'd0);
      check("timeout_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("timeout_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
      @(posedge clk); #1;

      // Reset on the second BUSY cycle
      chk_en = 1'b0;
      valid_in = 1'b1; ctr_mem_read = 1'b1; ctr_mem_write = 1'b0; ctr_branch = 1'b0;
      ctr_reg_write = 1'b1; alu_in = 32'h300; mem_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstbusy_pre_req", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; valid_in = 1'b0; ctr_mem_read = 1'b0;
      err_since = BIG;
      chk_en = 1'b1;
      @(negedge clk);
      check("rstbusy_mem_req", {31'd0, mem_req}, 32'd0);
      check("rstbusy_stall", {31'd0, stall}, 32'd0);
      check("rstbusy_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rstbusy_mem_err", {31'd0, mem_err}, 32'd0);
      @(posedge clk); #1;

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         repeat ($urandom_range(0, 2))
            run_instr(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, 5'($urandom), 4'($urandom), 0, $urandom);
         kind = $urandom_range(0, 9);
         if (kind < 4) begin
            run_instr(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, 5'($urandom), 4'($urandom), 0, $urandom);
         end else begin
            w = $urandom_range(0, 9);
            if (w < 6)       waits = w;
            else if (w < 8)  waits = $urandom_range(6, 15);
            else if (w == 8) waits = TO - 1;
            else             waits = $urandom_range(TO, TO + 4);
            case ($urandom_range(0, 2))
               0:       run_instr(1, 1, 0, 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                                  $urandom, 5'($urandom), 4'($urandom), waits, $urandom);
               1:       run_instr(1, 0, 1, 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                                  $urandom, 5'($urandom), 4'($urandom), waits, $urandom);
               default: run_instr(1, 1, 1, 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                                  $urandom, 5'($urandom), 4'($urandom), waits, $urandom);
            endcase
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
